// File: rtl/sdf_ray_marcher_pkg.sv
// rtl/sdf_ray_marcher_pkg.sv - shared fixed-point types, FSM states and vector helpers for the SDF ray marcher
package sdf_ray_marcher_pkg;

  localparam int BITS  = 32;
  localparam int FIXED = 16;

  typedef logic signed [BITS-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_POINT,
    ST_ISSUE,
    ST_WAIT,
    ST_EVAL,
    ST_DONE
  } march_state_t;

  // Largest positive t; the march saturates here so it always ends as a miss.
  localparam fixed_t T_MAX = {1'b0, {(BITS-1){1'b1}}};

  function automatic fixed_t mult(input fixed_t a, input fixed_t b);
    logic signed [2*BITS-1:0] prod;
    prod = (2*BITS)'(a) * (2*BITS)'(b);
    return BITS'(prod >>> FIXED);
  endfunction

  function automatic fixed_t to_fixed(input int whole);
    return whole <<< FIXED;
  endfunction

  function automatic vec3_t vec3_add(input vec3_t a, input vec3_t b);
    vec3_t r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    r.z = a.z + b.z;
    return r;
  endfunction

  function automatic vec3_t vec3_scale(input vec3_t v, input fixed_t s);
    vec3_t r;
    r.x = mult(s, v.x);
    r.y = mult(s, v.y);
    r.z = mult(s, v.z);
    return r;
  endfunction

endpackage

// File: rtl/sdf_ray_marcher_ray_point_calc.sv
// rtl/sdf_ray_marcher_ray_point_calc.sv - registered 3-lane multiply-add producing the query point O + t*D
module sdf_ray_marcher_ray_point_calc
  import sdf_ray_marcher_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  vec3_t                  org,
  input  vec3_t                  dir,
  input  logic signed [BITS-1:0] t,
  output vec3_t                  point
);

  // Only loads while enabled so the point stays put for the whole query.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      point <= '0;
    end else if (en) begin
      point <= vec3_add(org, vec3_scale(dir, t));
    end
  end

endmodule

// File: rtl/sdf_ray_marcher.sv
// rtl/sdf_ray_marcher.sv - marches one ray through an SDF block via a start/done query handshake
module sdf_ray_marcher
  import sdf_ray_marcher_pkg::*;
#(
  parameter int     MAX_STEPS   = 64,
  parameter fixed_t HIT_EPS     = 32'sh0000_0400,
  parameter fixed_t MAX_DIST    = 32'sh0064_0000,
  parameter int     SDF_TIMEOUT = 1024
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   ray_start,
  input  logic signed [BITS-1:0] ray_ox,
  input  logic signed [BITS-1:0] ray_oy,
  input  logic signed [BITS-1:0] ray_oz,
  input  logic signed [BITS-1:0] ray_dx,
  input  logic signed [BITS-1:0] ray_dy,
  input  logic signed [BITS-1:0] ray_dz,
  output logic                   ray_busy,
  output logic                   ray_done,
  output logic                   hit_out,
  output logic                   timeout_out,
  output logic signed [BITS-1:0] t_out,
  output logic [7:0]             steps_out,
  output logic [7:0]             red_out,
  output logic [7:0]             green_out,
  output logic [7:0]             blue_out,
  output logic                   sdf_start,
  output logic signed [BITS-1:0] sdf_x,
  output logic signed [BITS-1:0] sdf_y,
  output logic signed [BITS-1:0] sdf_z,
  input  logic                   sdf_done,
  input  logic signed [BITS-1:0] sdf_dist,
  input  logic [7:0]             sdf_red_in,
  input  logic [7:0]             sdf_green_in,
  input  logic [7:0]             sdf_blue_in
);

  localparam int TW = $clog2(SDF_TIMEOUT) + 1;

  march_state_t    state;
  vec3_t           org;
  vec3_t           dir;
  vec3_t           point;
  fixed_t          t;
  fixed_t          dist_q;
  logic [7:0]      steps;
  logic [TW-1:0]   tcnt;
  logic [7:0]      col_r;
  logic [7:0]      col_g;
  logic [7:0]      col_b;
  logic [BITS:0]   t_wide;
  fixed_t          t_sum;

  sdf_ray_marcher_ray_point_calc u_point (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .en    (state == ST_POINT),
    .org   (org),
    .dir   (dir),
    .t     (t),
    .point (point)
  );

  assign sdf_x = point.x;
  assign sdf_y = point.y;
  assign sdf_z = point.z;

  // One extra bit catches positive overflow of t + dist before saturating.
  always_comb begin
    t_wide = (BITS+1)'(t) + (BITS+1)'(dist_q);
    t_sum  = ($signed(t_wide) > $signed((BITS+1)'(T_MAX))) ? T_MAX : BITS'(t_wide);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ST_IDLE;
      org         <= '0;
      dir         <= '0;
      t           <= '0;
      dist_q      <= '0;
      steps       <= '0;
      tcnt        <= '0;
      col_r       <= '0;
      col_g       <= '0;
      col_b       <= '0;
      ray_busy    <= 1'b0;
      ray_done    <= 1'b0;
      hit_out     <= 1'b0;
      timeout_out <= 1'b0;
      t_out       <= '0;
      steps_out   <= '0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      sdf_start   <= 1'b0;
    end else begin
      ray_done  <= 1'b0;
      sdf_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ray_start) begin
            org      <= '{x: ray_ox, y: ray_oy, z: ray_oz};
            dir      <= '{x: ray_dx, y: ray_dy, z: ray_dz};
            t        <= '0;
            steps    <= '0;
            tcnt     <= '0;
            ray_busy <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          hit_out     <= 1'b0;
          timeout_out <= 1'b0;
          t_out       <= '0;
          steps_out   <= '0;
          red_out     <= '0;
          green_out   <= '0;
          blue_out    <= '0;
          state       <= ST_POINT;
        end
        ST_POINT: begin
          sdf_start <= 1'b1;
          state     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          steps <= steps + 8'd1;
          tcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (sdf_done) begin
            dist_q <= sdf_dist;
            col_r  <= sdf_red_in;
            col_g  <= sdf_green_in;
            col_b  <= sdf_blue_in;
            state  <= ST_EVAL;
          end else if (tcnt == TW'(SDF_TIMEOUT - 2)) begin
            // This cycle is the counter's step to SDF_TIMEOUT-1: abandon the query.
            timeout_out <= 1'b1;
            hit_out     <= 1'b0;
            t_out       <= t;
            steps_out   <= steps;
            ray_done    <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_EVAL: begin
          if (dist_q < HIT_EPS) begin
            hit_out   <= 1'b1;
            red_out   <= col_r;
            green_out <= col_g;
            blue_out  <= col_b;
            t_out     <= t;
            steps_out <= steps;
            ray_done  <= 1'b1;
            state     <= ST_DONE;
          end else if ((t_sum > MAX_DIST) || (steps == 8'(MAX_STEPS))) begin
            t         <= t_sum;
            t_out     <= t_sum;
            steps_out <= steps;
            ray_done  <= 1'b1;
            state     <= ST_DONE;
          end else begin
            t     <= t_sum;
            state <= ST_POINT;
          end
        end
        ST_DONE: begin
          ray_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
